// File: rtl/mips_id_stage.sv
// rtl/mips_id_stage.sv - MIPS decode stage: control decode, 32x32 regfile, sign extend, ID/EX register
// Optional macro WB_BYPASS_EN: same-cycle writeback data forwarded onto the read ports.
module mips_id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ID_ir,
    input  logic [31:0] ID_npc,
    input  logic        WB_wen,
    input  logic [31:0] WB_wdata,
    input  logic [4:0]  WB_rd,
    output logic [1:0]  EX_ctlwb,
    output logic [2:0]  EX_ctlm,
    output logic [3:0]  EX_ctlex,
    output logic [31:0] EX_npc,
    output logic [31:0] EX_rd1,
    output logic [31:0] EX_rd2,
    output logic [31:0] EX_imm,
    output logic [4:0]  EX_rt,
    output logic [4:0]  EX_rd
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  ctlwb;
    logic [2:0]  ctlm;
    logic [3:0]  ctlex;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] regs [32];
    logic        wb_write;

    assign op  = ID_ir[31:26];
    assign rs  = ID_ir[25:21];
    assign rt  = ID_ir[20:16];
    assign rd  = ID_ir[15:11];
    assign imm = {{16{ID_ir[15]}}, ID_ir[15:0]};

    assign wb_write = WB_wen && (WB_rd != 5'd0);

    // Unknown opcodes decode to an all-zero bubble.
    always_comb begin
        ctlwb = 2'b00;
        ctlm  = 3'b000;
        ctlex = 4'b0000;
        case (op)
            OP_RTYPE: begin ctlex = 4'b1100; ctlm = 3'b000; ctlwb = 2'b10; end
            OP_LW:    begin ctlex = 4'b0001; ctlm = 3'b010; ctlwb = 2'b11; end
            OP_SW:    begin ctlex = 4'b0001; ctlm = 3'b001; ctlwb = 2'b00; end
            OP_BEQ:   begin ctlex = 4'b0010; ctlm = 3'b100; ctlwb = 2'b00; end
            default:  begin ctlex = 4'b0000; ctlm = 3'b000; ctlwb = 2'b00; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_write) begin
            regs[WB_rd] <= WB_wdata;
        end
    end

    always_comb begin
        rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
        rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];
`ifdef WB_BYPASS_EN
        if (wb_write && (WB_rd == rs)) begin
            rd1 = WB_wdata;
        end
        if (wb_write && (WB_rd == rt)) begin
            rd2 = WB_wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_ctlwb <= 2'b00;
            EX_ctlm  <= 3'b000;
            EX_ctlex <= 4'b0000;
            EX_npc   <= 32'd0;
            EX_rd1   <= 32'd0;
            EX_rd2   <= 32'd0;
            EX_imm   <= 32'd0;
            EX_rt    <= 5'd0;
            EX_rd    <= 5'd0;
        end else begin
            EX_ctlwb <= ctlwb;
            EX_ctlm  <= ctlm;
            EX_ctlex <= ctlex;
            EX_npc   <= ID_npc;
            EX_rd1   <= rd1;
            EX_rd2   <= rd2;
            EX_imm   <= imm;
            EX_rt    <= rt;
            EX_rd    <= rd;
        end
    end

endmodule

// File: tb/tb_mips_id_stage.sv
// tb/tb_mips_id_stage.sv - table vectors, corner sequences and randomized model check for mips_id_stage
module tb_mips_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ID_ir;
    logic [31:0] ID_npc;
    logic        WB_wen;
    logic [31:0] WB_wdata;
    logic [4:0]  WB_rd;
    logic [1:0]  EX_ctlwb;
    logic [2:0]  EX_ctlm;
    logic [3:0]  EX_ctlex;
    logic [31:0] EX_npc;
    logic [31:0] EX_rd1;
    logic [31:0] EX_rd2;
    logic [31:0] EX_imm;
    logic [4:0]  EX_rt;
    logic [4:0]  EX_rd;

    typedef logic [146:0] obs_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] npc;
        logic [3:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_regs [32];
    vec_t        tbl [5];
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    mips_id_stage dut (
        .clk(clk), .rst_n(rst_n), .ID_ir(ID_ir), .ID_npc(ID_npc),
        .WB_wen(WB_wen), .WB_wdata(WB_wdata), .WB_rd(WB_rd),
        .EX_ctlwb(EX_ctlwb), .EX_ctlm(EX_ctlm), .EX_ctlex(EX_ctlex),
        .EX_npc(EX_npc), .EX_rd1(EX_rd1), .EX_rd2(EX_rd2), .EX_imm(EX_imm),
        .EX_rt(EX_rt), .EX_rd(EX_rd)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        return {EX_ctlwb, EX_ctlm, EX_ctlex, EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd};
    endfunction

    function automatic obs_t pack(logic [1:0] wb, logic [2:0] m, logic [3:0] ex, logic [31:0] npc,
                                  logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
                                  logic [4:0] rt, logic [4:0] rd);
        return {wb, m, ex, npc, r1, r2, imm, rt, rd};
    endfunction

    function automatic logic [31:0] read_model(logic [4:0] idx, logic wen, logic [4:0] wrd, logic [31:0] wdata);
        if (idx == 0) return 32'd0;
        if (BYPASS && wen && wrd == idx) return wdata;
        return model_regs[idx];
    endfunction

    function automatic obs_t predict(logic [31:0] ir, logic [31:0] npc, logic wen, logic [4:0] wrd, logic [31:0] wdata);
        logic [8:0]  ctl;
        logic [15:0] low;
        logic [31:0] sext;
        case (ir[31:26])
            6'h00:   ctl = 9'b10_000_1100;
            6'h23:   ctl = 9'b11_010_0001;
            6'h2B:   ctl = 9'b00_001_0001;
            6'h04:   ctl = 9'b00_100_0010;
            default: ctl = 9'b0;
        endcase
        low  = ir[15:0];
        sext = $signed(low);
        return {ctl, npc, read_model(ir[25:21], wen, wrd, wdata), read_model(ir[20:16], wen, wrd, wdata),
                sext, ir[20:16], ir[15:11]};
    endfunction

    task automatic check(string name, obs_t exp);
        n_vec++;
        if (observed() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, observed(), exp);
        end
    endtask

    task automatic drive(logic [31:0] ir, logic [31:0] npc, logic wen, logic [4:0] wrd, logic [31:0] wdata);
        ID_ir = ir; ID_npc = npc; WB_wen = wen; WB_rd = wrd; WB_wdata = wdata;
        @(posedge clk);
        #1;
        if (rst_n && wen && wrd != 0) model_regs[wrd] = wdata;
    endtask

    initial begin
        obs_t exp;
        logic [31:0] ir, npc, wdata;
        logic [5:0]  op;
        logic        wen;
        logic [4:0]  wrd;

        tbl[0] = '{"add",  32'h00221820, 32'h8,  4'b1100, 3'b000, 2'b10, 32'd5, 32'd7, 32'h00001820, 5'd2, 5'd3};
        tbl[1] = '{"lw",   32'h8C22FFFC, 32'hC,  4'b0001, 3'b010, 2'b11, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd2, 5'd31};
        tbl[2] = '{"sw",   32'hAC220004, 32'h10, 4'b0001, 3'b001, 2'b00, 32'd5, 32'd7, 32'h00000004, 5'd2, 5'd0};
        tbl[3] = '{"beq",  32'h10220003, 32'h14, 4'b0010, 3'b100, 2'b00, 32'd5, 32'd7, 32'h00000003, 5'd2, 5'd0};
        tbl[4] = '{"jbub", 32'h08000000, 32'h18, 4'b0000, 3'b000, 2'b00, 32'd0, 32'd0, 32'h00000000, 5'd0, 5'd0};
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

        rst_n = 1'b0; ID_ir = 32'hFFFF_FFFF; ID_npc = 32'h1234; WB_wen = 1'b1; WB_rd = 5'd1; WB_wdata = 32'h55;
        #1;
        check("reset_state", '0);
        @(negedge clk);
        check("reset_hold", '0);
        rst_n = 1'b1;

        drive(32'h0, 32'h0, 1'b1, 5'd1, 32'd5);
        drive(32'h0, 32'h4, 1'b1, 5'd2, 32'd7);
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].ir, tbl[i].npc, 1'b0, 5'd0, 32'd0);
            check(tbl[i].name, pack(tbl[i].wb, tbl[i].m, tbl[i].ex, tbl[i].npc, tbl[i].rd1,
                                    tbl[i].rd2, tbl[i].imm, tbl[i].rt, tbl[i].rd));
        end

        drive(32'h00000000, 32'h20, 1'b1, 5'd0, 32'hDEADBEEF);
        check("r0_same_cycle", pack(2'b10, 3'b000, 4'b1100, 32'h20, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0));
        drive(32'h00000000, 32'h24, 1'b0, 5'd0, 32'd0);
        check("r0_after", pack(2'b10, 3'b000, 4'b1100, 32'h24, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0));

        drive(32'h00800000, 32'h28, 1'b1, 5'd4, 32'h1234);
        check("bypass_rs", pack(2'b10, 3'b000, 4'b1100, 32'h28, BYPASS ? 32'h1234 : 32'd0, 32'd0, 32'd0, 5'd0, 5'd0));
        drive(32'h00800000, 32'h2C, 1'b0, 5'd0, 32'd0);
        check("r4_next", pack(2'b10, 3'b000, 4'b1100, 32'h2C, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0));
        drive(32'h00040000, 32'h30, 1'b1, 5'd4, 32'h5678);
        check("bypass_rt", pack(2'b10, 3'b000, 4'b1100, 32'h30, 32'd0, BYPASS ? 32'h5678 : 32'h1234, 32'd0, 5'd4, 5'd0));

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ir    = {op, 26'($urandom)};
            npc   = $urandom;
            wen   = 1'($urandom);
            wrd   = ($urandom_range(2) == 0) ? ir[25:21] : 5'($urandom);
            wdata = $urandom;
            exp   = predict(ir, npc, wen, wrd, wdata);
            drive(ir, npc, wen, wrd, wdata);
            check("random", exp);
        end

        drive(32'h8C22FFFC, 32'h40, 1'b1, 5'd1, 32'hAAAA);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", '0);
        ID_ir = 32'h8C22FFFC; ID_npc = 32'h44; WB_wen = 1'b1; WB_rd = 5'd2; WB_wdata = 32'hBBBB;
        @(posedge clk);
        #1;
        check("reset_blocks_write", '0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        drive(32'h00221820, 32'h48, 1'b0, 5'd0, 32'd0);
        check("regs_cleared", pack(2'b10, 3'b000, 4'b1100, 32'h48, 32'd0, 32'd0, 32'h00001820, 5'd2, 5'd3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_id_stage.md
Name: mips_id_stage

Overview:
- Instruction-decode stage of a 5-stage MIPS pipeline, placed between the fetch stage (IF/ID register: ID_ir, ID_npc) and the execute stage.
- Contains the main control decoder, a 32x32 register file written from writeback, and a 16-to-32 sign extender.
- All results are registered into the ID/EX pipeline register, which drives the EX_* outputs.

Parameters:
- none (word width fixed at 32, 32 registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_ir  in  32  instruction from IF/ID
- ID_npc  in  32  PC+4 from IF/ID
- WB_wen  in  1  register-file write enable from MEM/WB
- WB_wdata  in  32  register-file write data from WB mux
- WB_rd  in  5  register-file write index
- EX_ctlwb  out  2  {RegWrite, MemtoReg}
- EX_ctlm  out  3  {Branch, MemRead, MemWrite}
- EX_ctlex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- EX_npc  out  32  registered ID_npc
- EX_rd1  out  32  registered regfile[rs]
- EX_rd2  out  32  registered regfile[rt]
- EX_imm  out  32  registered sign-extended ID_ir[15:0]
- EX_rt  out  5  registered ID_ir[20:16]
- EX_rd  out  5  registered ID_ir[15:11]

Behaviour:
- Field extraction:
  - op = ID_ir[31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - imm = {{16{ID_ir[15]}}, ID_ir[15:0]}.
- Control decode is combinational from op; encodings are {ctlex, ctlm, ctlwb}:
  - 0x00 R-type: 1100, 000, 10
  - 0x23 lw: 0001, 010, 11
  - 0x2B sw: 0001, 001, 00
  - 0x04 beq: 0010, 100, 00
  - any other opcode: all zero (bubble; no writes, no memory access, no branch).
- Register file:
  - 32 x 32-bit, two combinational read ports (rs, rt), one write port.
  - Write occurs on the rising clk edge when WB_wen=1 and WB_rd!=0.
  - Register 0 always reads 0; writes to it are ignored.
- ID/EX register:
  - All EX_* outputs update on the rising clk edge.
  - Latency from ID_ir/ID_npc to EX_* is exactly 1 cycle; no stall or flush inputs.
- Reset (rst_n=0, asynchronous):
  - All EX_* outputs and all 32 registers clear to 0 immediately.
  - Reset held across edges blocks all writes.
  - Deassertion is sampled on the next rising edge.
- Simultaneous read and write of the same register is resolved by the optional feature below.
- Unused instruction fields (funct, shamt) pass through only via EX_imm.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when WB_wen=1, WB_rd!=0 and WB_rd equals rs (or rt), the corresponding read port returns WB_wdata in the same cycle. EX_rd1/EX_rd2 therefore capture the value being written, emulating write-first-half / read-second-half.
- Undefined: the read ports return the pre-write register contents. The new value is visible only from the following cycle.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 mid-cycle.
  - Response: all EX_* = 0 without waiting for a clock edge; regfile reads 0.
- Writeback then R-type:
  - Stimulus: write r1=5, r2=7 via WB; then ID_ir=0x00221820 (add $3,$1,$2), ID_npc=0x8.
  - Response: next edge EX_rd1=5, EX_rd2=7, EX_rt=2, EX_rd=3, EX_ctlex=1100, EX_ctlm=000, EX_ctlwb=10, EX_npc=0x8.
- lw with negative offset:
  - Stimulus: ID_ir=0x8C22FFFC.
  - Response: EX_imm=0xFFFFFFFC, EX_ctlex=0001, EX_ctlm=010, EX_ctlwb=11.
- sw, beq and unknown opcode:
  - Stimulus: 0xAC220004, 0x10220003, 0x08000000.
  - Response: ctl {0001,001,00}, {0010,100,00}, all zero respectively.
- r0 protection:
  - Stimulus: WB_wen=1, WB_rd=0, WB_wdata=0xDEADBEEF, then read rs=0.
  - Response: EX_rd1=0.
- Bypass:
  - Stimulus: same-cycle WB write r4=0x1234 while ID_ir reads rs=4.
  - Response: EX_rd1=0x1234 with WB_BYPASS_EN; old value (0) without it.
